// File: rtl/zxdma_pkg.sv
// Shared types and constants for the ZX-bus DMA engine.
package zxdma_pkg;

   localparam int ZXDMA_ADDR_W = 21;

   localparam logic [1:0] REG_ALO  = 2'd0;
   localparam logic [1:0] REG_AMID = 2'd1;
   localparam logic [1:0] REG_AHI  = 2'd2;
   localparam logic [1:0] REG_STAT = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_HOLD,
      WR_HOLD,
      WR_REQ
   } state_t;

endpackage

// File: rtl/zxdma_sync_edge.sv
// Multi-flop synchronizer for an asynchronous ZX strobe with rise/fall pulses
// taken from the two oldest (fully settled) flops.
module zxdma_sync_edge #(
   parameter int SYNC_DEPTH = 3
) (
   input  logic cpu_clock,
   input  logic rst_n,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_DEPTH-1:0] r_sync;

   always_ff @(posedge cpu_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], i_async};
      end
   end

   assign o_rise = (r_sync[SYNC_DEPTH-1:SYNC_DEPTH-2] == 2'b01);
   assign o_fall = (r_sync[SYNC_DEPTH-1:SYNC_DEPTH-2] == 2'b10);

endmodule

// File: rtl/zxdma_engine.sv
// Turns each ZX DMA-window memory cycle into one NGS memory byte transfer
// using an auto-incrementing address counter programmed by the NGS CPU.
module zxdma_engine
   import zxdma_pkg::*;
#(
   parameter int ADDR_W     = ZXDMA_ADDR_W,
   parameter int SYNC_DEPTH = 3
) (
   input  logic              cpu_clock,
   input  logic              rst_n,
   input  logic              dma_on,
   input  logic              zx_dmaread,
   input  logic              zx_dmawrite,
   input  logic [7:0]        zx_data_written,
   output logic              wait_ena,
   output logic [7:0]        dma_data_toberead,
   input  logic              reg_wr,
   input  logic [1:0]        reg_sel,
   input  logic [7:0]        reg_din,
   output logic [7:0]        reg_dout,
   output logic              mem_req,
   output logic              mem_rnw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wd,
   input  logic [7:0]        mem_rd,
   input  logic              mem_ack,
   output logic              busy
);

   state_t              r_state;
   state_t              w_next;
   logic                w_rd_rise, w_rd_fall, w_wr_rise, w_wr_fall;
   logic                w_inc, w_start_rd, w_start_wr, w_latch_rd;
   logic [ADDR_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]   w_cnt_next;
   logic [23:0]         w_cnt_pad;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_rnw;
   logic [7:0]          r_mem_wd;
   logic [7:0]          r_rd_data;

   zxdma_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_rd (
      .cpu_clock (cpu_clock),
      .rst_n     (rst_n),
      .i_async   (zx_dmaread),
      .o_rise    (w_rd_rise),
      .o_fall    (w_rd_fall)
   );

   zxdma_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_wr (
      .cpu_clock (cpu_clock),
      .rst_n     (rst_n),
      .i_async   (zx_dmawrite),
      .o_rise    (w_wr_rise),
      .o_fall    (w_wr_fall)
   );

   always_ff @(posedge cpu_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Losing dma_on in a HOLD state abandons the cycle; in a REQ state the
   // memory transaction is always allowed to finish first.
   always_comb begin
      w_next     = r_state;
      w_inc      = 1'b0;
      w_start_rd = 1'b0;
      w_start_wr = 1'b0;
      w_latch_rd = 1'b0;
      case (r_state)
         IDLE: begin
            if (dma_on && w_rd_rise) begin
               w_next     = RD_REQ;
               w_start_rd = 1'b1;
            end else if (dma_on && w_wr_rise) begin
               w_next = WR_HOLD;
            end
         end
         RD_REQ: begin
            if (mem_ack) begin
               w_latch_rd = 1'b1;
               w_next     = dma_on ? RD_HOLD : IDLE;
            end
         end
         RD_HOLD: begin
            if (!dma_on) begin
               w_next = IDLE;
            end else if (w_rd_fall) begin
               w_inc  = 1'b1;
               w_next = IDLE;
            end
         end
         WR_HOLD: begin
            if (!dma_on) begin
               w_next = IDLE;
            end else if (w_wr_fall) begin
               w_start_wr = 1'b1;
               w_next     = WR_REQ;
            end
         end
         WR_REQ: begin
            if (mem_ack) begin
               w_inc  = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // A CPU register write overrides only its own byte of the incremented value.
   always_comb begin
      w_cnt_next = w_inc ? (r_cnt + ADDR_W'(1)) : r_cnt;
      if (reg_wr) begin
         case (reg_sel)
            REG_ALO:  w_cnt_next[7:0]         = reg_din;
            REG_AMID: w_cnt_next[15:8]        = reg_din;
            REG_AHI:  w_cnt_next[ADDR_W-1:16] = reg_din[ADDR_W-17:0];
            default:  ;
         endcase
      end
   end

   always_ff @(posedge cpu_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_mem_addr <= '0;
         r_mem_rnw  <= 1'b1;
         r_mem_wd   <= '0;
         r_rd_data  <= '0;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_start_rd) begin
            r_mem_addr <= r_cnt;
            r_mem_rnw  <= 1'b1;
         end
         if (w_start_wr) begin
            r_mem_addr <= r_cnt;
            r_mem_rnw  <= 1'b0;
            r_mem_wd   <= zx_data_written;
         end
         if (w_latch_rd) begin
            r_rd_data <= mem_rd;
         end
      end
   end

   assign w_cnt_pad = 24'(r_cnt);

   always_comb begin
      case (reg_sel)
         REG_ALO:  reg_dout = w_cnt_pad[7:0];
         REG_AMID: reg_dout = w_cnt_pad[15:8];
         REG_AHI:  reg_dout = w_cnt_pad[23:16];
         default:  reg_dout = {7'b0, busy};
      endcase
   end

   // WAIT is pre-armed while idle so the ZX is caught as soon as its cycle starts.
   assign wait_ena = rst_n && dma_on && ((r_state == IDLE) || (r_state == RD_REQ));
   assign mem_req  = (r_state == RD_REQ) || (r_state == WR_REQ);
   assign busy     = (r_state != IDLE);

   assign mem_rnw           = r_mem_rnw;
   assign mem_addr          = r_mem_addr;
   assign mem_wd            = r_mem_wd;
   assign dma_data_toberead = r_rd_data;

endmodule

// File: tb/tb_zxdma_engine.sv
// Directed self-checking bench for zxdma_engine.
module tb_zxdma_engine;

   logic        cpu_clock = 1'b0;
   logic        rst_n;
   logic        dma_on;
   logic        zx_dmaread;
   logic        zx_dmawrite;
   logic [7:0]  zx_data_written;
   logic        wait_ena;
   logic [7:0]  dma_data_toberead;
   logic        reg_wr;
   logic [1:0]  reg_sel;
   logic [7:0]  reg_din;
   logic [7:0]  reg_dout;
   logic        mem_req;
   logic        mem_rnw;
   logic [20:0] mem_addr;
   logic [7:0]  mem_wd;
   logic [7:0]  mem_rd;
   logic        mem_ack;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   zxdma_engine #(.ADDR_W(21), .SYNC_DEPTH(3)) dut (
      .cpu_clock         (cpu_clock),
      .rst_n             (rst_n),
      .dma_on            (dma_on),
      .zx_dmaread        (zx_dmaread),
      .zx_dmawrite       (zx_dmawrite),
      .zx_data_written   (zx_data_written),
      .wait_ena          (wait_ena),
      .dma_data_toberead (dma_data_toberead),
      .reg_wr            (reg_wr),
      .reg_sel           (reg_sel),
      .reg_din           (reg_din),
      .reg_dout          (reg_dout),
      .mem_req           (mem_req),
      .mem_rnw           (mem_rnw),
      .mem_addr          (mem_addr),
      .mem_wd            (mem_wd),
      .mem_rd            (mem_rd),
      .mem_ack           (mem_ack),
      .busy              (busy)
   );

   always #5 cpu_clock = ~cpu_clock;

   task automatic cyc(input int n);
      repeat (n) @(posedge cpu_clock);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] sel, input logic [7:0] din);
      reg_sel = sel;
      reg_din = din;
      reg_wr  = 1'b1;
      cyc(1);
      reg_wr  = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] sel, input logic [7:0] exp, input string name);
      reg_sel = sel;
      #1;
      vectors++;
      if (reg_dout !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %02h expected %02h", name, reg_dout, exp);
      end
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (mem_req !== 1'b1 && n < 12) begin
         cyc(1);
         n++;
      end
      vectors++;
      if (mem_req !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s: mem_req got %b expected 1 within 12 cycles", name, mem_req);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 12) begin
         cyc(1);
         n++;
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL %s: busy got %b expected 0 within 12 cycles", name, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; dma_on = 1'b1; zx_dmaread = 1'b0; zx_dmawrite = 1'b0;
      zx_data_written = 8'h00; reg_wr = 1'b0; reg_sel = 2'd0; reg_din = 8'h00;
      mem_rd = 8'h00; mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         zx_dmaread = ~zx_dmaread;
         zx_dmawrite = ~zx_dmawrite;
         cyc(1);
      end
      zx_dmaread = 1'b0; zx_dmawrite = 1'b0;
      cyc(2);
      vectors++;
      if ({wait_ena, mem_req, mem_rnw, busy} !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: {wait,req,rnw,busy} got %b expected 0010",
                  {wait_ena, mem_req, mem_rnw, busy});
      end
      vectors++;
      if (mem_addr !== 21'h0 || mem_wd !== 8'h00 || dma_data_toberead !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_data: addr %h wd %h rd %h expected all zero",
                  mem_addr, mem_wd, dma_data_toberead);
      end
      read_reg(2'd0, 8'h00, "reset_alo");
      rst_n = 1'b1;
      #1;
      vectors++;
      if (wait_ena !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_release_wait: got %b expected 1", wait_ena);
      end
      cyc(1);
   endtask

   task automatic test_read();
      write_reg(2'd0, 8'h45);
      write_reg(2'd1, 8'h23);
      write_reg(2'd2, 8'h01);
      read_reg(2'd0, 8'h45, "prog_alo");
      read_reg(2'd1, 8'h23, "prog_amid");
      read_reg(2'd2, 8'h01, "prog_ahi");
      zx_dmaread = 1'b1;
      wait_req("rd_req");
      vectors++;
      if (mem_addr !== 21'h012345 || mem_rnw !== 1'b1 || wait_ena !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rd_req_fields: addr %h rnw %b wait %b expected 012345 1 1",
                  mem_addr, mem_rnw, wait_ena);
      end
      read_reg(2'd3, 8'h01, "rd_status_busy");
      cyc(3);
      mem_rd = 8'hA5;
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      mem_rd = 8'h00;
      #1;
      vectors++;
      if (wait_ena !== 1'b0 || mem_req !== 1'b0 || dma_data_toberead !== 8'hA5) begin
         miscompares++;
         $display("[TB] FAIL rd_hold: wait %b req %b data %h expected 0 0 a5",
                  wait_ena, mem_req, dma_data_toberead);
      end
      read_reg(2'd0, 8'h45, "rd_no_early_inc");
      zx_dmaread = 1'b0;
      wait_idle("rd_done");
      read_reg(2'd0, 8'h46, "rd_inc_alo");
   endtask

   task automatic test_write();
      logic seen = 1'b0;
      zx_dmawrite = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         if (wait_ena === 1'b0) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("[TB] FAIL wr_wait_drop: wait_ena got %b expected 0 within 3 cycles", wait_ena);
      end
      vectors++;
      if (mem_req !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wr_hold_noreq: mem_req got %b expected 0", mem_req);
      end
      zx_data_written = 8'h5A;
      zx_dmawrite = 1'b0;
      wait_req("wr_req");
      vectors++;
      if (mem_rnw !== 1'b0 || mem_addr !== 21'h012346 || mem_wd !== 8'h5A) begin
         miscompares++;
         $display("[TB] FAIL wr_req_fields: rnw %b addr %h wd %h expected 0 012346 5a",
                  mem_rnw, mem_addr, mem_wd);
      end
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wr_done: req %b busy %b expected 0 0", mem_req, busy);
      end
      read_reg(2'd0, 8'h47, "wr_inc_alo");
   endtask

   task automatic test_wrap();
      write_reg(2'd0, 8'hFF);
      write_reg(2'd1, 8'hFF);
      write_reg(2'd2, 8'h1F);
      zx_dmaread = 1'b1;
      wait_req("wrap_req");
      vectors++;
      if (mem_addr !== 21'h1FFFFF) begin
         miscompares++;
         $display("[TB] FAIL wrap_addr: got %h expected 1fffff", mem_addr);
      end
      mem_rd = 8'h3C;
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      zx_dmaread = 1'b0;
      wait_idle("wrap_done");
      vectors++;
      if (dma_data_toberead !== 8'h3C) begin
         miscompares++;
         $display("[TB] FAIL wrap_data: got %h expected 3c", dma_data_toberead);
      end
      read_reg(2'd2, 8'h00, "wrap_ahi");
      read_reg(2'd1, 8'h00, "wrap_amid");
      read_reg(2'd0, 8'h00, "wrap_alo");
   endtask

   task automatic test_abort();
      logic held = 1'b1;
      zx_dmaread = 1'b1;
      wait_req("abort_req");
      dma_on = 1'b0;
      #1;
      vectors++;
      if (wait_ena !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_wait: got %b expected 0", wait_ena);
      end
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (mem_req !== 1'b1) held = 1'b0;
      end
      vectors++;
      if (!held) begin
         miscompares++;
         $display("[TB] FAIL abort_req_held: mem_req got %b expected 1 until ack", mem_req);
      end
      mem_rd = 8'h99;
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || mem_req !== 1'b0 || dma_data_toberead !== 8'h99) begin
         miscompares++;
         $display("[TB] FAIL abort_end: busy %b req %b data %h expected 0 0 99",
                  busy, mem_req, dma_data_toberead);
      end
      read_reg(2'd0, 8'h00, "abort_no_inc");
      zx_dmaread = 1'b0;
      cyc(5);
      dma_on = 1'b1;
      cyc(1);
   endtask

   task automatic test_back_to_back();
      write_reg(2'd0, 8'hFF);
      write_reg(2'd1, 8'h00);
      write_reg(2'd2, 8'h00);
      zx_dmawrite = 1'b1;
      cyc(4);
      zx_data_written = 8'h11;
      zx_dmawrite = 1'b0;
      wait_req("coll_req");
      vectors++;
      if (mem_addr !== 21'h0000FF || mem_wd !== 8'h11) begin
         miscompares++;
         $display("[TB] FAIL coll_fields: addr %h wd %h expected 0000ff 11", mem_addr, mem_wd);
      end
      mem_ack = 1'b1;
      reg_sel = 2'd0;
      reg_din = 8'h77;
      reg_wr = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      reg_wr = 1'b0;
      read_reg(2'd0, 8'h77, "coll_alo");
      read_reg(2'd1, 8'h01, "coll_amid");
      read_reg(2'd2, 8'h00, "coll_ahi");
      write_reg(2'd3, 8'hFF);
      read_reg(2'd0, 8'h77, "stat_write_ignored");
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_wrap();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
